// File: rtl/cdc_src_arbiter.sv
// cdc_src_arbiter
// ----------------------------------------------------------------------------
// Source-domain scheduler that shares one two-phase (toggle) req/ack CDC
// crossing among NUM_REQ local requesters. Valid/ready requesters are
// round-robin arbitrated. The winner's {ID, payload} is registered onto the
// async bus and async_req_o is toggled. No further grant is issued until the
// synchronized acknowledge toggle comes back.
//
// Optional feature (compile-time macro CDC_SRC_ARB_TIMEOUT_EN):
//   Adds a sticky watchdog flag timeout_o. It is raised after TIMEOUT_CYCLES
//   clk_i cycles spent waiting for an acknowledge. The FSM keeps waiting
//   afterwards; the toggle protocol is never abandoned.
//
// Ports:
//   clk_i         source-domain clock
//   rst_ni        asynchronous active-low reset
//   req_valid_i   per-requester valid
//   req_data_i    packed payloads, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o   one-hot accept (combinational)
//   async_req_o   request toggle to the destination domain
//   async_data_o  {grant ID, payload}, stable while a crossing is outstanding
//   async_ack_i   acknowledge toggle from the destination domain
//   busy_o        crossing outstanding
//   grant_id_o    ID of the most recently granted requester
//   timeout_o     sticky watchdog flag (only with CDC_SRC_ARB_TIMEOUT_EN)
//
// State table:
//   IDLE     | arbitrating; a grant is issued whenever any valid is high
//   WAIT_ACK | crossing outstanding; waiting for the ack toggle to return
// ----------------------------------------------------------------------------
module cdc_src_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          async_req_o,
   output logic [IDW+DATA_WIDTH-1:0]     async_data_o,
   input  logic                          async_ack_i,
   output logic                          busy_o,
   output logic [IDW-1:0]                grant_id_o
`ifdef CDC_SRC_ARB_TIMEOUT_EN
   ,
   output logic                          timeout_o
`endif
);

   if (NUM_REQ < 1 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("cdc_src_arbiter: illegal parameter value");
   end

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [IDW-1:0]         rr_ptr_q;
   logic [IDW-1:0]         ptr_nxt;
   logic [IDW-1:0]         win_id;
   logic [DATA_WIDTH-1:0]  win_data;
   logic                   found;
   logic                   any_valid;
   logic                   xfer;
   int                     cand;

   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   ack_s;
   logic                   ack_prev_q;
   logic                   ack_evt;

   // ------------------------------------------------------------------------
   // Acknowledge synchronizer and toggle-edge detect
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_sync_q <= '0;
         ack_prev_q <= 1'b0;
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], async_ack_i};
         ack_prev_q <= ack_s;
      end
   end

   assign ack_s   = ack_sync_q[SYNC_STAGES-1];
   assign ack_evt = ack_s ^ ack_prev_q;

   // ------------------------------------------------------------------------
   // Round-robin arbiter: first valid at or above the pointer, with wrap
   // ------------------------------------------------------------------------
   always_comb begin
      win_id = '0;
      found  = 1'b0;
      cand   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!found && req_valid_i[IDW'(cand)]) begin
            found  = 1'b1;
            win_id = IDW'(cand);
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_id == IDW'(k)) begin
            win_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign any_valid = |req_valid_i;
   assign ptr_nxt   = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);

   // A transfer happens whenever IDLE sees any valid: ready is always raised
   // on the winner, which is by construction valid.
   assign xfer = (state_q == IDLE) && any_valid;

   // Ready is gated by rst_ni so it reads zero while reset is held even if
   // requesters keep their valids high.
   always_comb begin
      req_ready_o = '0;
      if (rst_ni && xfer) begin
         req_ready_o = NUM_REQ'(1) << win_id;
      end
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // An ack toggle seen in IDLE is a stray and is deliberately ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (ack_evt) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q == WAIT_ACK);

   // ------------------------------------------------------------------------
   // Async bus and grant bookkeeping. async_data_o only moves on the same edge
   // that toggles async_req_o, so the destination sees settled data.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         async_req_o  <= 1'b0;
         async_data_o <= '0;
         grant_id_o   <= '0;
         rr_ptr_q     <= '0;
      end else if (xfer) begin
         async_req_o  <= ~async_req_o;
         async_data_o <= {win_id, win_data};
         grant_id_o   <= win_id;
         rr_ptr_q     <= ptr_nxt;
      end
   end

`ifdef CDC_SRC_ARB_TIMEOUT_EN
   // ------------------------------------------------------------------------
   // Watchdog: counts WAIT_ACK cycles from entry and saturates at the limit.
   // The flag rises on the edge where the count reaches TIMEOUT_CYCLES.
   // ------------------------------------------------------------------------
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TCW-1:0] wd_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_cnt_q  <= '0;
         timeout_o <= 1'b0;
      end else begin
         if (xfer) begin
            wd_cnt_q <= '0;
         end else if (state_q == WAIT_ACK && wd_cnt_q != TCW'(TIMEOUT_CYCLES)) begin
            wd_cnt_q <= wd_cnt_q + TCW'(1);
         end
         if (state_q == WAIT_ACK && wd_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            timeout_o <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cdc_src_arbiter.sv
module tb_cdc_src_arbiter;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int SS  = 2;
   localparam int IDW = 2;
`ifdef CDC_SRC_ARB_TIMEOUT_EN
   localparam int TO  = 16;
`else
   localparam int TO  = 1024;
`endif
   // Loopback: 3 bench flops + SS sync flops + 1 edge-detect flop of busy
   localparam int LAT = 3 + SS + 1;
   localparam int OW  = N + 2 + IDW + IDW + DW;

   logic                 clk_i = 1'b0;
   logic                 rst_ni = 1'b1;
   logic [N-1:0]         vld = '0;
   logic [N*DW-1:0]      dat = '0;
   logic [N-1:0]         req_ready_o;
   logic                 async_req_o;
   logic [IDW+DW-1:0]    async_data_o;
   logic                 async_ack_i;
   logic                 busy_o;
   logic [IDW-1:0]       grant_id_o;
`ifdef CDC_SRC_ARB_TIMEOUT_EN
   logic                 timeout_o;
`endif

   logic [2:0]           lb_q;
   logic                 lb_en = 1'b1;
   logic                 stray = 1'b0;

   int total = 0;
   int bad   = 0;

   // reference model state
   int                   m_ptr  = 0;
   int                   m_busy = 0;
   logic                 m_req  = 1'b0;
   logic [IDW-1:0]       m_gid  = '0;
   logic [IDW+DW-1:0]    m_data = '0;
   bit                   m_granted = 1'b0;

   always #5 clk_i = ~clk_i;

   // destination-side stand-in: request toggle echoed back after 3 flops
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lb_q <= '0;
      else if (lb_en) lb_q <= {lb_q[1:0], async_req_o};
   end
   assign async_ack_i = lb_q[2] ^ stray;

   cdc_src_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(vld), .req_data_i(dat), .req_ready_o(req_ready_o),
      .async_req_o(async_req_o), .async_data_o(async_data_o),
      .async_ack_i(async_ack_i), .busy_o(busy_o), .grant_id_o(grant_id_o)
`ifdef CDC_SRC_ARB_TIMEOUT_EN
      , .timeout_o(timeout_o)
`endif
   );

   function automatic int winner(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++) begin
         int idx = (p + i) % N;
         if (((v >> idx) & N'(1)) != '0) return idx;
      end
      return -1;
   endfunction

   function automatic logic [OW-1:0] obs_now();
      return {req_ready_o, busy_o, async_req_o, grant_id_o, async_data_o};
   endfunction

   function automatic logic [OW-1:0] obs_exp();
      logic [N-1:0] rdy = '0;
      int w = winner(vld, m_ptr);
      if (m_busy == 0 && w >= 0) rdy = N'(1) << w;
      return {rdy, m_busy != 0, m_req, m_gid, m_data};
   endfunction

   // one clock edge of the abstract model: either wait out the round trip or
   // hand the crossing to the round-robin winner
   function automatic void model_adv();
      int w;
      m_granted = 1'b0;
      if (m_busy > 0) begin
         m_busy--;
      end else begin
         w = winner(vld, m_ptr);
         if (w >= 0) begin
            m_req     = ~m_req;
            m_gid     = IDW'(w);
            m_data    = {IDW'(w), DW'(dat >> (w * DW))};
            m_ptr     = (w + 1) % N;
            m_busy    = LAT;
            m_granted = 1'b1;
         end
      end
   endfunction

   function automatic void model_reset();
      m_ptr = 0; m_busy = 0; m_req = 1'b0; m_gid = '0; m_data = '0;
      m_granted = 1'b0;
   endfunction

   task automatic idle_flush();
      vld = '0;
      repeat (LAT + 1) begin
         @(negedge clk_i);
         model_adv();
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_reset();
      #3 rst_ni = 1'b0;
      vld = '1;
      repeat (2) @(posedge clk_i);
      #1;
      total++;
      if (obs_now() !== '0) begin
         bad++;
         $display("FAIL reset_values got=%h exp=0", obs_now());
      end
      vld = '0;
      model_reset();
      rst_ni = 1'b1;
      @(negedge clk_i);
      total++;
      if (obs_now() !== obs_exp()) begin
         bad++;
         $display("FAIL reset_idle got=%h exp=%h", obs_now(), obs_exp());
      end
      model_adv();
      @(posedge clk_i); #1;
   endtask

   task automatic test_fairness();
      int fair_seq[6] = '{0, 1, 2, 3, 0, 1};
      int n = 0;
      for (int c = 0; c < 6 * (LAT + 1); c++) begin
         vld = '1;
         dat = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk_i);
         total++;
         if (obs_now() !== obs_exp()) begin
            bad++;
            $display("FAIL fairness c=%0d got=%h exp=%h", c, obs_now(), obs_exp());
         end
         if (m_granted && n < 6) begin
            total++;
            if (grant_id_o !== IDW'(fair_seq[n])) begin
               bad++;
               $display("FAIL fair_order n=%0d got=%0d exp=%0d", n, grant_id_o, fair_seq[n]);
            end
            n++;
         end
         model_adv();
         @(posedge clk_i); #1;
      end
      idle_flush();
   endtask

   // pointer sits at 2 here: req0 alone must still win, then 1 beats 3
   task automatic test_pointer_skip();
      for (int c = 0; c < 2 * (LAT + 1); c++) begin
         vld = (c < LAT + 1) ? 4'b0001 : 4'b1010;
         dat = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk_i);
         total++;
         if (obs_now() !== obs_exp()) begin
            bad++;
            $display("FAIL ptr_skip c=%0d got=%h exp=%h", c, obs_now(), obs_exp());
         end
         if (c == 0 || c == LAT + 1) begin
            total++;
            if (req_ready_o !== ((c == 0) ? 4'b0001 : 4'b0010)) begin
               bad++;
               $display("FAIL ptr_skip_ready c=%0d got=%b", c, req_ready_o);
            end
         end
         model_adv();
         @(posedge clk_i); #1;
      end
      idle_flush();
   endtask

   task automatic test_single();
      logic [IDW+DW-1:0] exp_bus = {2'd1, 32'hA5A5_0001};
      for (int c = 0; c < LAT + 3; c++) begin
         vld = (c == 0) ? 4'b0010 : 4'b0000;
         dat = {$urandom, $urandom, 32'hA5A5_0001, $urandom};
         @(negedge clk_i);
         total++;
         if (obs_now() !== obs_exp()) begin
            bad++;
            $display("FAIL single c=%0d got=%h exp=%h", c, obs_now(), obs_exp());
         end
         if (c == 1) begin
            total++;
            if (async_data_o !== exp_bus) begin
               bad++;
               $display("FAIL single_bus got=%h exp=%h", async_data_o, exp_bus);
            end
         end
         model_adv();
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_stray_ack();
      stray = ~stray;
      for (int c = 0; c < 3 * (LAT + 1); c++) begin
         vld = (c < 8) ? 4'b0000 : 4'b0100;
         dat = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk_i);
         total++;
         if (obs_now() !== obs_exp()) begin
            bad++;
            $display("FAIL stray_ack c=%0d got=%h exp=%h", c, obs_now(), obs_exp());
         end
         model_adv();
         @(posedge clk_i); #1;
      end
      idle_flush();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         vld = N'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) vld = '0;
         dat = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk_i);
         total++;
         if (obs_now() !== obs_exp()) begin
            bad++;
            $display("FAIL random c=%0d got=%h exp=%h", c, obs_now(), obs_exp());
         end
         model_adv();
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_reset_midflight();
      int guard = 0;
      vld = '1;
      while (!(m_busy > 0 && m_busy < LAT - 1) && guard < 40) begin
         dat = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk_i);
         model_adv();
         @(posedge clk_i); #1;
         guard++;
      end
      total++;
      if (guard >= 40) begin
         bad++;
         $display("FAIL midflight_reach got=timeout exp=wait_ack");
      end
      rst_ni = 1'b0;
      stray  = 1'b0;
      #2;
      total++;
      if (obs_now() !== '0) begin
         bad++;
         $display("FAIL midflight_async got=%h exp=0", obs_now());
      end
      model_reset();
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      for (int c = 0; c < 2 * (LAT + 1); c++) begin
         vld = '1;
         dat = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk_i);
         total++;
         if (obs_now() !== obs_exp()) begin
            bad++;
            $display("FAIL midflight c=%0d got=%h exp=%h", c, obs_now(), obs_exp());
         end
         if (c == 0) begin
            total++;
            if (req_ready_o !== 4'b0001) begin
               bad++;
               $display("FAIL midflight_first got=%b exp=0001", req_ready_o);
            end
         end
         model_adv();
         @(posedge clk_i); #1;
      end
      idle_flush();
   endtask

`ifdef CDC_SRC_ARB_TIMEOUT_EN
   task automatic test_timeout();
      lb_en = 1'b0;
      vld   = 4'b0001;
      @(posedge clk_i); #1;
      vld = '0;
      for (int k = 1; k <= TO + 6; k++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         total++;
         if (timeout_o !== (k >= TO) || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL timeout k=%0d got=%b/%b exp=%b/1", k, timeout_o, busy_o, (k >= TO));
         end
      end
      rst_ni = 1'b0;
      #2;
      total++;
      if (timeout_o !== 1'b0) begin
         bad++;
         $display("FAIL timeout_reset got=%b exp=0", timeout_o);
      end
      lb_en = 1'b1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_fairness();
      test_pointer_skip();
      test_single();
      test_stray_ack();
      test_random();
      test_reset_midflight();
`ifdef CDC_SRC_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdc_src_arbiter.md
Name: cdc_src_arbiter

Overview:
Source-domain scheduler that shares one two-phase (toggle) req/ack CDC crossing among NUM_REQ local requesters. It sits in the transmitting clock domain and pairs with the destination-side toggle receiver. The block round-robin arbitrates valid/ready requesters, registers the winner's payload plus its ID onto the async bus, toggles the request, and blocks further grants until the synchronized acknowledge toggle returns.

Parameters:
NUM_REQ, 4, number of requester channels (>=1)
DATA_WIDTH, 32, payload width per requester
SYNC_STAGES, 2, synchronizer flops on async_ack_i (>=2)
TIMEOUT_CYCLES, 1024, watchdog limit in clk_i cycles; used only with CDC_SRC_ARB_TIMEOUT_EN

Ports:
clk_i  in  1  source-domain clock
rst_ni  in  1  reset, asynchronous, active-low
req_valid_i  in  NUM_REQ  per-requester valid
req_data_i  in  NUM_REQ*DATA_WIDTH  packed payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  out  NUM_REQ  one-hot accept; combinational
async_req_o  out  1  request toggle to destination domain
async_data_o  out  IDW+DATA_WIDTH  {grant ID, payload}; IDW = max(1, clog2(NUM_REQ))
async_ack_i  in  1  acknowledge toggle from destination domain
busy_o  out  1  high while a crossing is outstanding (state WAIT_ACK)
grant_id_o  out  IDW  ID of the most recently granted requester
timeout_o  out  1  watchdog flag; present only with CDC_SRC_ARB_TIMEOUT_EN

Behaviour:
- Reset values: state=IDLE, async_req_o=0, async_data_o=0, grant_id_o=0, busy_o=0, req_ready_o=0, RR pointer=0, ack synchronizer and ack_prev=0, timeout_o=0.
- Ack path: async_ack_i passes through SYNC_STAGES flops to give ack_s. ack_prev registers ack_s. ack_evt = ack_s XOR ack_prev.
- FSM states: IDLE and WAIT_ACK.
- IDLE, arbitration:
  - Winner g is the first k with req_valid_i[k]=1, searching from the RR pointer upward with wrap.
  - req_ready_o = onehot(g) when state=IDLE and any valid is high; otherwise all zeros.
  - There is no combinational path from req_valid_i[j] to req_ready_o[k] except through the arbiter.
- IDLE, transfer (valid&&ready on g), at the next edge:
  - async_data_o <= {g, req_data_i[g]}
  - async_req_o <= ~async_req_o
  - grant_id_o <= g
  - RR pointer <= (g+1) mod NUM_REQ
  - state <= WAIT_ACK
- Data stability: async_data_o changes only on the edge that toggles async_req_o. It is held constant for the whole WAIT_ACK period. The destination's request synchronizer guarantees the data has settled before it is sampled.
- WAIT_ACK: req_ready_o=0 and busy_o=1. On ack_evt, state <= IDLE.
- Throughput: at minimum, a new grant is possible one cycle after ack_evt. Per-transfer cost is one IDLE cycle plus the round-trip synchronizer latency.
- ack_evt in IDLE (stray or glitched toggle) is ignored. No state change and no grant side effects.
- Any valid may drop before it is granted; no grant results from a dropped valid. Once a transfer has occurred, the captured data is final.
- NUM_REQ=1: the arbiter degenerates and the pointer stays 0. The ID field is 1 bit, constant 0.
- Reset mid-operation (in WAIT_ACK): return to IDLE with async_req_o=0. Both CDC endpoints must be reset together. The toggle phase is not recovered across a one-sided reset.

Optional Feature:
Macro CDC_SRC_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When it reaches TIMEOUT_CYCLES, timeout_o is set. It stays sticky until reset.
  - The FSM remains in WAIT_ACK; the toggle protocol is never abandoned.
- Disabled: the timeout_o port, the counter and the TIMEOUT_CYCLES logic are absent.

Test Plan:
- Single transfer: req_valid_i=0010, data1=0xA5A5_0001, ack looped back via 3-flop delay. Expect req_ready_o=0010 for one cycle, async_data_o={ID 1, 0xA5A50001}, async_req_o toggles 0->1, busy_o falls 1 cycle after ack_evt.
- Fairness: all four valid continuously, loopback ack. Grant sequence is 0,1,2,3,0,1. Each ID appears exactly once per 4 grants.
- Pointer skip: pointer=2, only req 0 valid. Grant 0, then pointer=1. Next with reqs 1 and 3 valid: grant 1.
- Stray ack: toggle async_ack_i in IDLE with no valids. No async_req_o change, ready stays 0. A subsequent normal transfer still completes.
- Reset mid-flight: assert rst_ni low in WAIT_ACK. All outputs return to reset values asynchronously. After release, the first grant goes to req 0 when all are valid.
- Timeout (macro on, TIMEOUT_CYCLES=16): never toggle ack. timeout_o rises 16 cycles after WAIT_ACK entry, stays high, busy_o stays 1.
